sram_ctrl: RTL and testbench

//  Physical memory controller that sits directly below the MMU. It serves the dev_mem_* interface
//  (addr, data, is_write, busy) and drives one 32-bit asynchronous SRAM chip.
//  - Reads are combinational and complete in the same cycle.
//  - Writes run a multi-cycle state machine: latched setup, WE pulse, hold, then bus turnaround.
//  - busy is held high until the SRAM is ready for the next access.

---
 rtl/sram_ctrl_if.sv | 19 +
 rtl/sram_ctrl.sv | 114 +++++++++++
 tb/tb_sram_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_if.sv
// MMU-side request/response bundle for the SRAM controller.
`timescale 1ns/1ps
interface sram_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_is_write;
  logic [31:0] mem_data_out;
  logic        mem_busy;

  modport master (
    output mem_addr, mem_data_in, mem_is_write,
    input  mem_data_out, mem_busy
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_is_write,
    output mem_data_out, mem_busy
  );
endinterface

// File: rtl/sram_ctrl.sv
// Asynchronous 32-bit SRAM controller: same-cycle combinational reads,
// timed setup/pulse/hold/turnaround sequence for writes.
`timescale 1ns/1ps
module sram_ctrl #(
  parameter int ADDR_WIDTH   = 20,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_ctrl_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  inout  wire  [31:0]           sram_data_io,
  output logic                  sram_ce_n_o,
  output logic                  sram_oe_n_o,
  output logic                  sram_we_n_o
);

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, TURN} state_e;

  localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES)
                         ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                         : ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] wrAddr_q, wrAddr_d;
  logic [31:0]           wrData_q, wrData_d;
  logic                  weN_q, weN_d;
  logic                  idleRead;
  logic                  busDrive;
  logic                  unusedAddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      weN_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      weN_q    <= weN_d;
    end
  end

  // Each write phase loads its length minus one and advances when the count hits zero.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    case (state_q)
      IDLE: begin
        if (bus.mem_is_write) begin
          state_d  = SETUP;
          count_d  = SETUP_LOAD;
          wrAddr_d = bus.mem_addr[ADDR_WIDTH+1:2];
          wrData_d = bus.mem_data_in;
        end
      end
      SETUP: begin
        if (count_q == '0) begin
          state_d = PULSE;
          count_d = PULSE_LOAD;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      PULSE: begin
        if (count_q == '0) begin
          state_d = HOLD;
          count_d = HOLD_LOAD;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      HOLD: begin
        if (count_q == '0) begin
          state_d = TURN;
          count_d = '0;
        end else begin
          count_d = count_q - CW'(1);
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // we_n is registered from the next state so it can never glitch.
    weN_d = (state_d != PULSE);
  end

  assign idleRead = rst_n && (state_q == IDLE) && !bus.mem_is_write;
  assign busDrive = (state_q == SETUP) || (state_q == PULSE) || (state_q == HOLD);

  assign sram_data_io     = busDrive ? wrData_q : 32'bz;
  assign sram_addr_o      = (state_q == IDLE) ? bus.mem_addr[ADDR_WIDTH+1:2] : wrAddr_q;
  assign sram_ce_n_o      = ~rst_n;
  assign sram_oe_n_o      = ~idleRead;
  assign sram_we_n_o      = weN_q;
  assign bus.mem_busy     = rst_n && ((state_q != IDLE) || bus.mem_is_write);
  assign bus.mem_data_out = idleRead ? sram_data_io : 32'h0;

  assign unusedAddr = ^{bus.mem_addr[1:0], bus.mem_addr[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: default instance with an SRAM model, plus a
// narrow-address, slow-timing instance for wrap and span checks.
`timescale 1ns/1ps
module tb_sram_ctrl;
  logic clk;
  logic rst_n;

  sram_ctrl_if memIf ();
  sram_ctrl_if memIfB ();

  logic [19:0] sramAddr;
  wire  [31:0] sramData;
  logic        ceN, oeN, weN;
  logic [3:0]  sramAddrB;
  wire  [31:0] sramDataB;
  logic        ceNB, oeNB, weNB;

  logic [31:0] sramMem [0:255];
  logic [31:0] expMem  [0:255];
  logic [31:0] expQ [$];
  int assertCount = 0;
  int failCount   = 0;

  sram_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(memIf.slave),
    .sram_addr_o(sramAddr), .sram_data_io(sramData),
    .sram_ce_n_o(ceN), .sram_oe_n_o(oeN), .sram_we_n_o(weN)
  );

  sram_ctrl #(.ADDR_WIDTH(4), .SETUP_CYCLES(2), .PULSE_CYCLES(3), .HOLD_CYCLES(2)) dutB (
    .clk(clk), .rst_n(rst_n), .bus(memIfB.slave),
    .sram_addr_o(sramAddrB), .sram_data_io(sramDataB),
    .sram_ce_n_o(ceNB), .sram_oe_n_o(oeNB), .sram_we_n_o(weNB)
  );

  // Behavioural asynchronous SRAM: drives on oe_n, captures on the rising edge of we_n.
  assign sramData = (!ceN && !oeN && weN) ? sramMem[sramAddr[7:0]] : 32'bz;
  always @(posedge weN) if (rst_n && !ceN) sramMem[sramAddr[7:0]] <= sramData;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Read data must never be enabled while a write is pending or we_n is low.
  always @(negedge clk) begin
    #3;
    if (rst_n) checkOutput("noOverlap", {31'b0, !oeN && (!weN || memIf.mem_busy)}, 32'h0);
  end

  task automatic applyRead(input logic [31:0] addr);
    memIf.mem_is_write = 1'b0;
    memIf.mem_addr     = addr;
    expQ.push_back(expMem[addr[9:2]]);
    #1;
    checkOutput("rdData", memIf.mem_data_out, expQ.pop_front());
    checkOutput("rdAddr", {12'b0, sramAddr}, {12'b0, addr[21:2]});
    checkOutput("rdBusy", {31'b0, memIf.mem_busy}, 32'h0);
    checkOutput("rdOe", {31'b0, oeN}, 32'h0);
  endtask

  task automatic applyWrite(input logic [31:0] addr, input logic [31:0] data, input int violateAt,
                            input logic [31:0] violData, input int expSpan, input logic [15:0] expWeMask);
    int cyc;
    int span;
    logic [15:0] weMask;
    @(negedge clk);
    memIf.mem_is_write = 1'b1;
    memIf.mem_addr     = addr;
    memIf.mem_data_in  = data;
    expMem[addr[9:2]]  = data;
    #3;
    checkOutput("wrReqBusy", {31'b0, memIf.mem_busy}, 32'h1);
    checkOutput("wrReqOe", {31'b0, oeN}, 32'h1);
    cyc = 1; span = 1; weMask = '0;
    while (memIf.mem_busy && cyc < 15) begin
      @(negedge clk);
      cyc++;
      if (cyc == violateAt) begin
        memIf.mem_is_write = 1'b1;
        memIf.mem_addr     = addr ^ 32'h40;
        memIf.mem_data_in  = violData;
      end else begin
        memIf.mem_is_write = 1'b0;
        memIf.mem_addr     = ~addr;
        memIf.mem_data_in  = ~data;
      end
      #3;
      if (memIf.mem_busy) begin
        span = cyc;
        if (!weN) begin
          weMask[cyc] = 1'b1;
          checkOutput("wrAddrLatched", {12'b0, sramAddr}, {12'b0, addr[21:2]});
          checkOutput("wrBusData", sramData, data);
        end
        if (cyc == expSpan) checkOutput("turnBusReleased", {31'b0, sramData !== data}, 32'h1);
      end
    end
    if (memIf.mem_busy) checkOutput("wrTimeout", 32'h1, 32'h0);
    checkOutput("wrSpan", span, expSpan);
    checkOutput("wrWeMask", {16'b0, weMask}, {16'b0, expWeMask});
    checkOutput("wrStored", sramMem[addr[9:2]], data);
  endtask

  task automatic applyWriteB(input logic [31:0] addr, input logic [31:0] data);
    int cyc;
    int span;
    logic [15:0] weMask;
    @(negedge clk);
    memIfB.mem_is_write = 1'b1;
    memIfB.mem_addr     = addr;
    memIfB.mem_data_in  = data;
    #3;
    checkOutput("wrapIdleAddr", {28'b0, sramAddrB}, 32'h1);
    cyc = 1; span = 1; weMask = '0;
    while (memIfB.mem_busy && cyc < 15) begin
      @(negedge clk);
      cyc++;
      memIfB.mem_is_write = 1'b0;
      memIfB.mem_addr     = ~addr;
      memIfB.mem_data_in  = ~data;
      #3;
      if (memIfB.mem_busy) begin
        span = cyc;
        if (!weNB) weMask[cyc] = 1'b1;
      end
      if (cyc == 2) checkOutput("wrapLatchedAddr", {28'b0, sramAddrB}, 32'h1);
    end
    if (memIfB.mem_busy) checkOutput("wrBTimeout", 32'h1, 32'h0);
    checkOutput("slowSpan", span, 9);
    checkOutput("slowWeMask", {16'b0, weMask}, 32'h0070);
  endtask

  initial begin
    int waitCyc;
    logic [31:0] raddr;
    rst_n = 1'b0;
    memIf.mem_is_write  = 1'b0; memIf.mem_addr  = '0; memIf.mem_data_in  = '0;
    memIfB.mem_is_write = 1'b0; memIfB.mem_addr = '0; memIfB.mem_data_in = '0;
    for (int i = 0; i < 256; i++) begin
      sramMem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
      expMem[i]  = (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    end
    sramMem[4] = 32'hDEAD_BEEF;
    expMem[4]  = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    #3;
    checkOutput("rstBusy", {31'b0, memIf.mem_busy}, 32'h0);
    checkOutput("rstDataOut", memIf.mem_data_out, 32'h0);
    checkOutput("rstWe", {31'b0, weN}, 32'h1);
    checkOutput("rstOe", {31'b0, oeN}, 32'h1);
    checkOutput("rstCe", {31'b0, ceN}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("ceActive", {31'b0, ceN}, 32'h0);

    @(negedge clk);
    applyRead(32'h0000_0010);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      raddr = {$urandom_range(1023, 0), 12'b0, 8'($urandom_range(255, 0)), 2'($urandom_range(3, 0))};
      applyRead(raddr);
    end

    applyWrite(32'h0000_0020, 32'h1234_5678, 0, 32'h0, 6, 16'h0018);
    applyRead(32'h0000_0020);

    applyWrite(32'h0000_0030, 32'hCAFE_F00D, 5, 32'hBAD0_BAD0, 6, 16'h0018);
    @(negedge clk);
    applyRead(32'h0000_0030);
    @(negedge clk);
    applyRead(32'h0000_0070);

    @(negedge clk);
    memIf.mem_is_write = 1'b1;
    memIf.mem_addr     = 32'h0000_0080;
    memIf.mem_data_in  = 32'h5555_AAAA;
    waitCyc = 0;
    do begin
      @(negedge clk);
      memIf.mem_is_write = 1'b0;
      #3;
      waitCyc++;
    end while (weN && waitCyc < 10);
    checkOutput("pulseReached", {31'b0, weN}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstWe", {31'b0, weN}, 32'h1);
    checkOutput("asyncRstOe", {31'b0, oeN}, 32'h1);
    checkOutput("asyncRstBusy", {31'b0, memIf.mem_busy}, 32'h0);
    checkOutput("asyncRstBus", {31'b0, sramData !== 32'h5555_AAAA}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    checkOutput("postRstBusy", {31'b0, memIf.mem_busy}, 32'h0);
    checkOutput("postRstOe", {31'b0, oeN}, 32'h0);
    @(negedge clk);
    applyRead(32'h0000_0010);

    applyWriteB(32'h0000_0044, 32'h0BAD_F00D);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
